// File: rtl/axis_max_index_finder.sv
// AXI-Stream packet reducer: reports the extreme value of each packet, the
// zero-based index of its first occurrence and the saturating beat count.
module axis_max_index_finder #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 16,
  parameter bit          SIGNED     = 1'b0,
  parameter bit          MODE_MIN   = 1'b0
) (
  input  logic                  ACLK,
  input  logic                  ARESET_n,
  input  logic [DATA_WIDTH-1:0] S_TDATA,
  input  logic                  S_TVALID,
  input  logic                  S_TLAST,
  output logic                  S_TREADY,
  output logic [DATA_WIDTH-1:0] M_TDATA,
  output logic [IDX_WIDTH-1:0]  M_TIDX,
  output logic [IDX_WIDTH-1:0]  M_TCOUNT,
  output logic                  M_TOVF,
  output logic                  M_TVALID,
  input  logic                  M_TREADY
);

  localparam logic [IDX_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [IDX_WIDTH-1:0] CNT_ONE = IDX_WIDTH'(1);

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                state_q,    state_d;
  logic                  first_q,    first_d;
  logic [DATA_WIDTH-1:0] best_q,     best_d;
  logic [IDX_WIDTH-1:0]  best_idx_q, best_idx_d;
  logic [IDX_WIDTH-1:0]  cnt_q,      cnt_d;
  logic                  ovf_q,      ovf_d;
  logic                  s_tready_q, s_tready_d;
  logic [DATA_WIDTH-1:0] m_tdata_q,  m_tdata_d;
  logic [IDX_WIDTH-1:0]  m_tidx_q,   m_tidx_d;
  logic [IDX_WIDTH-1:0]  m_tcount_q, m_tcount_d;
  logic                  m_tovf_q,   m_tovf_d;
  logic                  m_tvalid_q, m_tvalid_d;

  logic                  beat_acc;
  logic                  cnt_sat;
  logic                  better;
  logic [DATA_WIDTH-1:0] cand_best;
  logic [IDX_WIDTH-1:0]  cand_idx;
  logic [IDX_WIDTH-1:0]  cand_cnt;
  logic                  cand_ovf;

  // Strict compare of the incoming sample against the running extreme.
  always_comb begin
    better = 1'b0;
    if (SIGNED) begin
      if (MODE_MIN) better = $signed(S_TDATA) < $signed(best_q);
      else          better = $signed(S_TDATA) > $signed(best_q);
    end else begin
      if (MODE_MIN) better = S_TDATA < best_q;
      else          better = S_TDATA > best_q;
    end
  end

  // Accumulator values after folding in the current beat.
  always_comb begin
    cnt_sat   = (cnt_q == CNT_MAX);
    cand_best = best_q;
    cand_idx  = best_idx_q;
    cand_cnt  = cnt_q;
    cand_ovf  = ovf_q;
    if (first_q) begin
      cand_best = S_TDATA;
      cand_idx  = '0;
      cand_cnt  = CNT_ONE;
      cand_ovf  = 1'b0;
    end else begin
      // cnt_q is already saturated past the limit, so the index saturates too.
      if (better) begin
        cand_best = S_TDATA;
        cand_idx  = cnt_q;
      end
      cand_cnt = cnt_sat ? cnt_q : cnt_q + CNT_ONE;
      cand_ovf = ovf_q | cnt_sat;
    end
  end

  assign beat_acc = S_TVALID && s_tready_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    first_d    = first_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    m_tdata_d  = m_tdata_q;
    m_tidx_d   = m_tidx_q;
    m_tcount_d = m_tcount_q;
    m_tovf_d   = m_tovf_q;
    m_tvalid_d = m_tvalid_q;

    case (state_q)
      SCAN: begin
        if (beat_acc) begin
          if (S_TLAST) begin
            m_tdata_d  = cand_best;
            m_tidx_d   = cand_idx;
            m_tcount_d = cand_cnt;
            m_tovf_d   = cand_ovf;
            m_tvalid_d = 1'b1;
            state_d    = HOLD;
            first_d    = 1'b1;
            best_d     = '0;
            best_idx_d = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
          end else begin
            first_d    = 1'b0;
            best_d     = cand_best;
            best_idx_d = cand_idx;
            cnt_d      = cand_cnt;
            ovf_d      = cand_ovf;
          end
        end
      end
      HOLD: begin
        if (m_tvalid_q && M_TREADY) begin
          m_tvalid_d = 1'b0;
          state_d    = SCAN;
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase

    s_tready_d = (state_d == SCAN);
  end

  // State and output registers; ready is held low while reset is asserted.
  always_ff @(posedge ACLK) begin
    if (!ARESET_n) begin
      state_q    <= SCAN;
      first_q    <= 1'b1;
      best_q     <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      s_tready_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tidx_q   <= '0;
      m_tcount_q <= '0;
      m_tovf_q   <= 1'b0;
      m_tvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      first_q    <= first_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      s_tready_q <= s_tready_d;
      m_tdata_q  <= m_tdata_d;
      m_tidx_q   <= m_tidx_d;
      m_tcount_q <= m_tcount_d;
      m_tovf_q   <= m_tovf_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

  assign S_TREADY = s_tready_q;
  assign M_TDATA  = m_tdata_q;
  assign M_TIDX   = m_tidx_q;
  assign M_TCOUNT = m_tcount_q;
  assign M_TOVF   = m_tovf_q;
  assign M_TVALID = m_tvalid_q;

endmodule

// File: tb/tb_axis_max_index_finder.sv
// Bench for axis_max_index_finder: several parameterisations share one stimulus
// stream; results are compared with a plain-arithmetic packet model.
module tb_axis_max_index_finder;

  typedef struct packed {
    logic [31:0] d;
    logic [15:0] i;
    logic [15:0] c;
    logic        o;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_last;
  logic [31:0] s_data;
  logic        m_ready_dir;
  logic        m_ready_rnd = 1'b1;
  logic        rnd_mode;
  wire         m_ready = rnd_mode ? m_ready_rnd : m_ready_dir;

  wire         s_ready, m_valid, m_ovf;
  wire  [31:0] m_data;
  wire  [15:0] m_idx, m_cnt;
  wire         sm_ready, sm_valid, sm_ovf;
  wire  [15:0] sm_data, sm_idx, sm_cnt;
  wire         mn_ready, mn_valid, mn_ovf;
  wire  [15:0] mn_data, mn_idx, mn_cnt;
  wire         u16_ready, u16_valid, u16_ovf;
  wire  [15:0] u16_data, u16_idx, u16_cnt;
  wire         i3_ready, i3_valid, i3_ovf;
  wire  [31:0] i3_data;
  wire  [2:0]  i3_idx, i3_cnt;

  int   errors = 0;
  int   checks = 0;
  res_t res_arr [4096];
  int   res_n = 0;
  res_t exp_arr [1000];

  always #5 clk = ~clk;

  axis_max_index_finder #(.DATA_WIDTH(32), .IDX_WIDTH(16), .SIGNED(1'b0), .MODE_MIN(1'b0)) dut (
    .ACLK(clk), .ARESET_n(rst_n), .S_TDATA(s_data), .S_TVALID(s_valid), .S_TLAST(s_last),
    .S_TREADY(s_ready), .M_TDATA(m_data), .M_TIDX(m_idx), .M_TCOUNT(m_cnt), .M_TOVF(m_ovf),
    .M_TVALID(m_valid), .M_TREADY(m_ready));

  axis_max_index_finder #(.DATA_WIDTH(16), .IDX_WIDTH(16), .SIGNED(1'b1), .MODE_MIN(1'b0)) dut_smax (
    .ACLK(clk), .ARESET_n(rst_n), .S_TDATA(s_data[15:0]), .S_TVALID(s_valid), .S_TLAST(s_last),
    .S_TREADY(sm_ready), .M_TDATA(sm_data), .M_TIDX(sm_idx), .M_TCOUNT(sm_cnt), .M_TOVF(sm_ovf),
    .M_TVALID(sm_valid), .M_TREADY(m_ready));

  axis_max_index_finder #(.DATA_WIDTH(16), .IDX_WIDTH(16), .SIGNED(1'b1), .MODE_MIN(1'b1)) dut_smin (
    .ACLK(clk), .ARESET_n(rst_n), .S_TDATA(s_data[15:0]), .S_TVALID(s_valid), .S_TLAST(s_last),
    .S_TREADY(mn_ready), .M_TDATA(mn_data), .M_TIDX(mn_idx), .M_TCOUNT(mn_cnt), .M_TOVF(mn_ovf),
    .M_TVALID(mn_valid), .M_TREADY(m_ready));

  axis_max_index_finder #(.DATA_WIDTH(16), .IDX_WIDTH(16), .SIGNED(1'b0), .MODE_MIN(1'b0)) dut_umax16 (
    .ACLK(clk), .ARESET_n(rst_n), .S_TDATA(s_data[15:0]), .S_TVALID(s_valid), .S_TLAST(s_last),
    .S_TREADY(u16_ready), .M_TDATA(u16_data), .M_TIDX(u16_idx), .M_TCOUNT(u16_cnt), .M_TOVF(u16_ovf),
    .M_TVALID(u16_valid), .M_TREADY(m_ready));

  axis_max_index_finder #(.DATA_WIDTH(32), .IDX_WIDTH(3), .SIGNED(1'b0), .MODE_MIN(1'b0)) dut_i3 (
    .ACLK(clk), .ARESET_n(rst_n), .S_TDATA(s_data), .S_TVALID(s_valid), .S_TLAST(s_last),
    .S_TREADY(i3_ready), .M_TDATA(i3_data), .M_TIDX(i3_idx), .M_TCOUNT(i3_cnt), .M_TOVF(i3_ovf),
    .M_TVALID(i3_valid), .M_TREADY(m_ready));

  // Record every result handshake of the main instance.
  always @(posedge clk) begin
    if (m_valid && m_ready && res_n < 4096) begin
      res_arr[res_n] <= '{d: m_data, i: m_idx, c: m_cnt, o: m_ovf};
      res_n          <= res_n + 1;
    end
  end

  // Random downstream readiness, applied only in the random phase.
  always begin
    @(posedge clk);
    #1;
    m_ready_rnd = ($urandom_range(0, 3) != 0);
  end

  // Reference: extreme by value, then earliest position, saturated to the index range.
  function automatic res_t model(input logic [31:0] d[$], input int dw, input bit sgn,
                                 input bit mn, input int iw);
    res_t   r;
    longint vals[$];
    longint v, ext, first_at, maxc, len;
    longint mask = (longint'(1) <<< dw) - 1;
    foreach (d[j]) begin
      v = longint'(d[j]) & mask;
      if (sgn && v >= (longint'(1) <<< (dw - 1))) v = v - (longint'(1) <<< dw);
      vals.push_back(v);
    end
    ext = vals[0];
    foreach (vals[j]) if (mn ? (vals[j] < ext) : (vals[j] > ext)) ext = vals[j];
    first_at = 0;
    for (int j = vals.size() - 1; j >= 0; j--) if (vals[j] == ext) first_at = longint'(j);
    maxc = (longint'(1) <<< iw) - 1;
    len  = longint'(vals.size());
    r.d  = 32'(ext & mask);
    r.i  = 16'((first_at > maxc) ? maxc : first_at);
    r.c  = 16'((len > maxc) ? maxc : len);
    r.o  = (len > maxc);
    return r;
  endfunction

  task automatic send_packet(input logic [31:0] d[$], input int gap_max, input bit with_last);
    int waited;
    bit acc;
    foreach (d[i]) begin
      if (gap_max > 0 && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, gap_max)) begin
          @(posedge clk);
          #1;
        end
      end
      s_valid = 1'b1;
      s_data  = d[i];
      s_last  = with_last && (i == d.size() - 1);
      waited  = 0;
      acc     = 1'b0;
      while (!acc && waited < 500) begin
        acc = s_ready;
        @(posedge clk);
        #1;
        waited++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL send_timeout beat %0d: S_TREADY=0 for 500 cycles, required 1", i);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_valid); end
    checks++; if ({m_data, m_idx, m_cnt, m_ovf} !== 65'd0) begin
      errors++; $display("FAIL reset_outputs got %h/%0d/%0d/%b want 0/0/0/0", m_data, m_idx, m_cnt, m_ovf);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_tready got %b want 1", s_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] pkt[$];
    pkt = '{32'd5, 32'd9, 32'd3, 32'd9, 32'd2};
    m_ready_dir = 1'b1;
    send_packet(pkt, 0, 1'b1);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_latency tvalid got %b want 1", m_valid); end
    checks++; if ({m_data, m_idx, m_cnt, m_ovf} !== {32'd9, 16'd1, 16'd5, 1'b0}) begin
      errors++; $display("FAIL basic_result got %0d/%0d/%0d/%b want 9/1/5/0", m_data, m_idx, m_cnt, m_ovf);
    end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL basic_hold_tready got %b want 0", s_ready); end
    @(posedge clk);
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle tvalid got %b want 0", m_valid); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back got %b want 1", s_ready); end
  endtask

  task automatic test_signed();
    logic [31:0] pkt[$];
    pkt = '{32'h0000_FFFF, 32'h0000_0003, 32'h0000_8000};
    m_ready_dir = 1'b1;
    send_packet(pkt, 0, 1'b1);
    checks++; if ({sm_valid, sm_data, sm_idx, sm_cnt, sm_ovf} !== {1'b1, 16'h0003, 16'd1, 16'd3, 1'b0}) begin
      errors++; $display("FAIL signed_max got v%b %h/%0d/%0d/%b want v1 0003/1/3/0", sm_valid, sm_data, sm_idx, sm_cnt, sm_ovf);
    end
    checks++; if ({mn_valid, mn_data, mn_idx, mn_cnt, mn_ovf} !== {1'b1, 16'h8000, 16'd2, 16'd3, 1'b0}) begin
      errors++; $display("FAIL signed_min got v%b %h/%0d/%0d/%b want v1 8000/2/3/0", mn_valid, mn_data, mn_idx, mn_cnt, mn_ovf);
    end
    checks++; if ({u16_valid, u16_data, u16_idx, u16_cnt, u16_ovf} !== {1'b1, 16'hFFFF, 16'd0, 16'd3, 1'b0}) begin
      errors++; $display("FAIL unsigned16_max got v%b %h/%0d/%0d/%b want v1 ffff/0/3/0", u16_valid, u16_data, u16_idx, u16_cnt, u16_ovf);
    end
    checks++; if ({sm_ready, mn_ready, u16_ready, i3_ready} !== 4'b0000) begin
      errors++; $display("FAIL signed_hold_tready got %b want 0000", {sm_ready, mn_ready, u16_ready, i3_ready});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] pkt[$];
    res_t        e;
    int          base;
    for (int k = 0; k < 6; k++) pkt.push_back($urandom_range(0, 65000));
    e = model(pkt, 32, 1'b0, 1'b0, 16);
    m_ready_dir = 1'b0;
    send_packet(pkt, 0, 1'b1);
    base = res_n;
    for (int c = 0; c < 10; c++) begin
      s_valid = 1'b1;
      s_data  = $urandom;
      s_last  = 1'($urandom_range(0, 1));
      checks++; if ({m_valid, s_ready, m_data, m_idx, m_cnt, m_ovf} !== {1'b1, 1'b0, e.d, e.i, e.c, e.o}) begin
        errors++; $display("FAIL bp_stable cyc %0d got v%b r%b %0d/%0d/%0d/%b want v1 r0 %0d/%0d/%0d/%b",
                           c, m_valid, s_ready, m_data, m_idx, m_cnt, m_ovf, e.d, e.i, e.c, e.o);
      end
      @(posedge clk);
      #1;
    end
    s_valid     = 1'b0;
    s_last      = 1'b0;
    m_ready_dir = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (m_valid !== 1'b0 || res_n != base + 1) begin
      errors++; $display("FAIL bp_release got tvalid %b results %0d want 0 and 1", m_valid, res_n - base);
    end
    pkt.delete();
    for (int k = 0; k < 4; k++) pkt.push_back($urandom_range(0, 65000));
    e = model(pkt, 32, 1'b0, 1'b0, 16);
    send_packet(pkt, 0, 1'b1);
    checks++; if ({m_valid, m_data, m_idx, m_cnt, m_ovf} !== {1'b1, e.d, e.i, e.c, e.o}) begin
      errors++; $display("FAIL bp_next got v%b %0d/%0d/%0d/%b want v1 %0d/%0d/%0d/%b",
                         m_valid, m_data, m_idx, m_cnt, m_ovf, e.d, e.i, e.c, e.o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow();
    logic [31:0] pkt[$];
    for (int k = 1; k <= 9; k++) pkt.push_back(32'(k));
    m_ready_dir = 1'b1;
    send_packet(pkt, 0, 1'b1);
    checks++; if ({i3_valid, i3_data, i3_idx, i3_cnt, i3_ovf} !== {1'b1, 32'd9, 3'd7, 3'd7, 1'b1}) begin
      errors++; $display("FAIL ovf_sat got v%b %0d/%0d/%0d/%b want v1 9/7/7/1", i3_valid, i3_data, i3_idx, i3_cnt, i3_ovf);
    end
    checks++; if ({m_cnt, m_idx, m_ovf} !== {16'd9, 16'd8, 1'b0}) begin
      errors++; $display("FAIL ovf_wide got %0d/%0d/%b want 9/8/0", m_cnt, m_idx, m_ovf);
    end
    @(posedge clk);
    #1;
    pkt = '{32'd0};
    send_packet(pkt, 0, 1'b1);
    checks++; if ({i3_valid, i3_data, i3_idx, i3_cnt, i3_ovf} !== {1'b1, 32'd0, 3'd0, 3'd1, 1'b0}) begin
      errors++; $display("FAIL ovf_single got v%b %0d/%0d/%0d/%b want v1 0/0/1/0", i3_valid, i3_data, i3_idx, i3_cnt, i3_ovf);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [31:0] pkt[$];
    int          base;
    int          waited;
    base     = res_n;
    rnd_mode = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      pkt.delete();
      repeat ($urandom_range(1, 50)) pkt.push_back($urandom_range(0, 65000));
      exp_arr[p] = model(pkt, 32, 1'b0, 1'b0, 16);
      send_packet(pkt, 2, 1'b1);
    end
    waited = 0;
    while (res_n - base < 1000 && waited < 2000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    repeat (20) @(posedge clk);
    #1;
    rnd_mode    = 1'b0;
    m_ready_dir = 1'b1;
    checks++; if (res_n - base != 1000) begin
      errors++; $display("FAIL rand_count got %0d results want 1000", res_n - base);
    end
    for (int p = 0; p < 1000; p++) begin
      checks++;
      if (base + p >= res_n || res_arr[base + p] !== exp_arr[p]) begin
        errors++;
        $display("FAIL rand_pkt %0d got %0d/%0d/%0d/%b want %0d/%0d/%0d/%b", p,
                 res_arr[base + p].d, res_arr[base + p].i, res_arr[base + p].c, res_arr[base + p].o,
                 exp_arr[p].d, exp_arr[p].i, exp_arr[p].c, exp_arr[p].o);
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [31:0] pkt[$];
    int          base;
    base        = res_n;
    m_ready_dir = 1'b1;
    pkt         = '{32'd100, 32'd200, 32'd300};
    send_packet(pkt, 0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++; if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_state got tvalid %b tready %b want 0 0", m_valid, s_ready);
    end
    pkt = '{32'd7, 32'd4};
    send_packet(pkt, 0, 1'b1);
    checks++; if ({m_valid, m_data, m_idx, m_cnt, m_ovf} !== {1'b1, 32'd7, 16'd0, 16'd2, 1'b0}) begin
      errors++; $display("FAIL midrst_result got v%b %0d/%0d/%0d/%b want v1 7/0/2/0", m_valid, m_data, m_idx, m_cnt, m_ovf);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (res_n - base != 1) begin
      errors++; $display("FAIL midrst_count got %0d results want 1", res_n - base);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    s_valid     = 1'b0;
    s_last      = 1'b0;
    s_data      = '0;
    m_ready_dir = 1'b1;
    rnd_mode    = 1'b0;
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_overflow();
    test_random();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
